// File: rtl/am_sdr_pkg.sv
// am_sdr_pkg: shared AM receiver widths, reset constants and sequencer state encoding.
package am_sdr_pkg;
  localparam int SDR_PHASE_W = 20;
  localparam int SDR_GAIN_W = 3;
  // Reset values come from the SPI config block reset word so both blocks power up agreeing
  localparam logic [23:0] SDR_CFG_RST_WORD = 24'h507380;
  localparam logic [SDR_PHASE_W-1:0] SDR_RST_PHASE = SDR_CFG_RST_WORD[19:0];
  localparam logic [SDR_GAIN_W-1:0] SDR_RST_GAIN = SDR_CFG_RST_WORD[22:20];
  typedef enum logic [2:0] {S_IDLE, S_RAMP_DN, S_APPLY, S_SETTLE, S_RAMP_UP} seq_state_t;
endpackage

// File: rtl/tune_sequencer_tick_counter.sv
// tick_counter: sample_tick-gated up-counter with clear; done flags the N-th tick.
module tick_counter #(
  parameter int N = 4
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic clr,
  input  logic tick,
  output logic done
);
  localparam int W = $clog2(N + 1);
  logic [W-1:0] cnt;
  assign done = tick && !clr && cnt == W'(N - 1);
  always_ff @(posedge CLK or negedge RSTb)
    if (!RSTb) cnt <= '0;
    else if (clr || done) cnt <= '0;
    else if (tick) cnt <= cnt + 1'b1;
endmodule

// File: rtl/tune_sequencer.sv
// tune_sequencer: click-free retune - mute gain, swap NCO increment on a tick, settle, ramp gain back.
module tune_sequencer
  import am_sdr_pkg::*;
#(
  parameter int PHASE_W = SDR_PHASE_W,
  parameter int GAIN_W = SDR_GAIN_W,
  parameter logic [PHASE_W-1:0] RST_PHASE = SDR_RST_PHASE,
  parameter logic [GAIN_W-1:0] RST_GAIN = SDR_RST_GAIN,
  parameter int SETTLE_TICKS = 4,
  parameter int DWELL_TICKS = 1024
) (
  input  logic               CLK,
  input  logic               RSTb,
  input  logic [PHASE_W-1:0] cfg_phase_inc,
  input  logic [GAIN_W-1:0]  cfg_gain,
  input  logic               cfg_valid,
  input  logic               sample_tick,
  input  logic               scan_en,
  input  logic [PHASE_W-1:0] scan_step,
  input  logic [PHASE_W-1:0] scan_min,
  input  logic [PHASE_W-1:0] scan_max,
  output logic [PHASE_W-1:0] nco_phase_inc,
  output logic [GAIN_W-1:0]  gain_out,
  output logic               busy,
  output logic               retuned
);
  seq_state_t state, idle_nx, pend_nx;
  logic [PHASE_W-1:0] tgt_phase, pend_phase, req_phase, scan_next;
  logic [GAIN_W-1:0] tgt_gain, pend_gain, req_gain, gain_step;
  logic [PHASE_W:0] scan_sum;
  logic pending, dwell_done, settle_done, ramp_up_done;
  tick_counter #(.N(DWELL_TICKS)) u_dwell (
    .CLK(CLK), .RSTb(RSTb), .clr(state != S_IDLE || !scan_en || cfg_valid),
    .tick(sample_tick), .done(dwell_done)
  );
  tick_counter #(.N(SETTLE_TICKS)) u_settle (
    .CLK(CLK), .RSTb(RSTb), .clr(state != S_SETTLE), .tick(sample_tick), .done(settle_done)
  );
  // Extra carry bit catches wrap past the top of the phase range
  assign scan_sum = {1'b0, nco_phase_inc} + {1'b0, scan_step};
  assign scan_next = (scan_sum[PHASE_W] || scan_sum[PHASE_W-1:0] > scan_max) ? scan_min : scan_sum[PHASE_W-1:0];
  assign req_phase = cfg_valid ? cfg_phase_inc : scan_next;
  assign req_gain = cfg_valid ? cfg_gain : tgt_gain;
  assign gain_step = gain_out < tgt_gain ? gain_out + 1'b1 : gain_out - 1'b1;
  assign ramp_up_done = gain_out == tgt_gain || (sample_tick && gain_step == tgt_gain);
  always_comb begin
    idle_nx = req_phase != nco_phase_inc ? S_RAMP_DN : req_gain != gain_out ? S_RAMP_UP : S_IDLE;
    pend_nx = pend_phase != nco_phase_inc ? S_RAMP_DN : pend_gain != tgt_gain ? S_RAMP_UP : S_IDLE;
  end
  always_ff @(posedge CLK or negedge RSTb)
    if (!RSTb) begin
      state <= S_IDLE;
      nco_phase_inc <= RST_PHASE;
      gain_out <= RST_GAIN;
      tgt_phase <= RST_PHASE;
      tgt_gain <= RST_GAIN;
      pend_phase <= RST_PHASE;
      pend_gain <= RST_GAIN;
      pending <= 1'b0;
      busy <= 1'b0;
      retuned <= 1'b0;
    end else begin
      retuned <= 1'b0;
      case (state)
        S_IDLE:
          if (cfg_valid || dwell_done) begin
            tgt_phase <= req_phase;
            tgt_gain <= req_gain;
            state <= idle_nx;
            busy <= idle_nx != S_IDLE;
          end
        S_RAMP_DN: begin
          if (sample_tick && gain_out != '0) gain_out <= gain_out - 1'b1;
          if (gain_out == '0 || (sample_tick && gain_out == GAIN_W'(1))) state <= S_APPLY;
        end
        S_APPLY:
          if (sample_tick) begin
            nco_phase_inc <= tgt_phase;
            retuned <= 1'b1;
            state <= S_SETTLE;
          end
        S_SETTLE:
          if (settle_done) state <= S_RAMP_UP;
        default: begin
          if (sample_tick && gain_out != tgt_gain) gain_out <= gain_step;
          if (ramp_up_done) begin
            state <= pending ? pend_nx : S_IDLE;
            busy <= pending && pend_nx != S_IDLE;
            pending <= 1'b0;
            if (pending) begin
              tgt_phase <= pend_phase;
              tgt_gain <= pend_gain;
            end
          end
        end
      endcase
      // Requests arriving mid-sequence queue up; the last one wins
      if (cfg_valid && state != S_IDLE) begin
        pend_phase <= cfg_phase_inc;
        pend_gain <= cfg_gain;
        pending <= 1'b1;
      end
    end
endmodule

// File: tb/tb_tune_sequencer.sv
// tb_tune_sequencer: table vectors, randomized requests vs a per-tick trace model, hand-written corner sequences.
module tb_tune_sequencer;
  localparam int SETTLE = 4;
  logic CLK = 1'b0;
  logic RSTb = 1'b1;
  logic [19:0] cfg_phase_inc = '0, scan_step = '0, scan_min = '0, scan_max = '0;
  logic [2:0] cfg_gain = '0;
  logic cfg_valid = 1'b0, sample_tick = 1'b0, scan_en = 1'b0;
  logic [19:0] nco_phase_inc;
  logic [2:0] gain_out;
  logic busy, retuned;
  int tests = 0, fails = 0, ret_total = 0;
  int m_gain;
  logic [19:0] m_nco;

  typedef struct {logic [19:0] p; int g; int ticks; int rets;} vec_t;
  typedef struct {int g; logic [19:0] p; int r;} exp_t;
  vec_t tab[7];

  tune_sequencer #(.SETTLE_TICKS(SETTLE), .DWELL_TICKS(4)) dut (
    .CLK(CLK), .RSTb(RSTb), .cfg_phase_inc(cfg_phase_inc), .cfg_gain(cfg_gain),
    .cfg_valid(cfg_valid), .sample_tick(sample_tick), .scan_en(scan_en),
    .scan_step(scan_step), .scan_min(scan_min), .scan_max(scan_max),
    .nco_phase_inc(nco_phase_inc), .gain_out(gain_out), .busy(busy), .retuned(retuned)
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (retuned === 1'b1) ret_total++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic gap_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      repeat (2) cyc();
    end
  endtask

  task automatic send_cfg(input logic [19:0] p, input logic [2:0] g);
    cfg_phase_inc = p;
    cfg_gain = g;
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  // Tick until idle; reports tick count, retune pulses, nco at first retune and whether 0x09000 appeared
  task automatic run_idle(output int nt, output int nr, output logic [19:0] first, output bit seen9);
    nt = 0; nr = 0; first = '0; seen9 = 0;
    while (busy && nt < 200) begin
      tick();
      nt++;
      if (retuned) begin
        if (nr == 0) first = nco_phase_inc;
        nr++;
      end
      if (nco_phase_inc == 20'h09000) seen9 = 1;
      repeat (2) cyc();
    end
    chk("idle_reached", {31'b0, busy}, 32'd0);
  endtask

  // Expected per-tick (gain, nco, retuned) trace built from the retune rules
  task automatic run_req(input logic [19:0] p, input int g, output int nt, output int nr);
    exp_t q[$];
    exp_t e;
    if (p != m_nco) begin
      for (int k = m_gain - 1; k >= 0; k--) q.push_back('{k, m_nco, 0});
      q.push_back('{0, p, 1});
      for (int k = 0; k < SETTLE; k++) q.push_back('{0, p, 0});
      for (int k = 1; k <= g; k++) q.push_back('{k, p, 0});
    end else begin
      for (int k = m_gain; k != g; ) begin
        k = k < g ? k + 1 : k - 1;
        q.push_back('{k, p, 0});
      end
    end
    send_cfg(p, g[2:0]);
    cyc();
    nt = 0; nr = 0;
    while (busy && nt < 100) begin
      tick();
      nt++;
      if (retuned) nr++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("trace_gain", {29'b0, gain_out}, e.g);
        chk("trace_nco", {12'b0, nco_phase_inc}, {12'b0, e.p});
        chk("trace_retuned", {31'b0, retuned}, e.r);
      end else begin
        tests++;
        fails++;
        $display("FAIL trace_extra_tick: busy still %0b after %0d ticks, required 0", busy, nt);
      end
      repeat (2) cyc();
    end
    chk("trace_left", q.size(), 32'd0);
    chk("req_busy_low", {31'b0, busy}, 32'd0);
    chk("req_nco", {12'b0, nco_phase_inc}, {12'b0, p});
    chk("req_gain", {29'b0, gain_out}, g);
    m_nco = p;
    m_gain = g;
  endtask

  initial begin
    int nt, nr, r0;
    logic [19:0] first;
    bit seen9;
    tab[0] = '{20'h08000, 3, 13, 1};
    tab[1] = '{20'h08000, 5, 2, 0};
    tab[2] = '{20'h08000, 7, 2, 0};
    tab[3] = '{20'h08000, 7, 0, 0};
    tab[4] = '{20'h0C000, 0, 12, 1};
    tab[5] = '{20'h0C100, 2, 7, 1};
    tab[6] = '{20'h0C100, 0, 2, 0};
    #2 RSTb = 1'b0;
    #1;
    chk("rst_nco", {12'b0, nco_phase_inc}, 32'h07380);
    chk("rst_gain", {29'b0, gain_out}, 32'd5);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    repeat (3) cyc();
    #4 RSTb = 1'b1;
    cyc();
    r0 = ret_total;
    gap_ticks(100);
    chk("rst_no_retune", ret_total - r0, 32'd0);
    chk("rst_hold_nco", {12'b0, nco_phase_inc}, 32'h07380);
    chk("rst_hold_gain", {29'b0, gain_out}, 32'd5);
    chk("rst_hold_busy", {31'b0, busy}, 32'd0);
    m_nco = 20'h07380;
    m_gain = 5;
    foreach (tab[i]) begin
      run_req(tab[i].p, tab[i].g, nt, nr);
      chk($sformatf("vec%0d_ticks", i), nt, tab[i].ticks);
      chk($sformatf("vec%0d_retunes", i), nr, tab[i].rets);
    end
    for (int i = 0; i < 25; i++)
      run_req($urandom_range(0, 2) == 0 ? m_nco : 20'($urandom), int'($urandom_range(0, 7)), nt, nr);
    // Two requests queued while busy: only the last survives
    run_req(20'h0C100, 6, nt, nr);
    send_cfg(20'h0B000, 3'd2);
    send_cfg(20'h09000, 3'd7);
    tick();
    repeat (2) cyc();
    send_cfg(20'h0A000, 3'd4);
    run_idle(nt, nr, first, seen9);
    chk("pend_retunes", nr, 32'd2);
    chk("pend_first_nco", {12'b0, first}, 32'h0B000);
    chk("pend_skipped_09000", {31'b0, seen9}, 32'd0);
    chk("pend_final_nco", {12'b0, nco_phase_inc}, 32'h0A000);
    chk("pend_final_gain", {29'b0, gain_out}, 32'd4);
    m_nco = 20'h0A000;
    m_gain = 4;
    // Scan wraps past scan_max to scan_min
    run_req(20'h00300, 2, nt, nr);
    scan_min = 20'h00100;
    scan_max = 20'h00300;
    scan_step = 20'h00100;
    scan_en = 1'b1;
    gap_ticks(3);
    chk("scan_dwell_wait", {31'b0, busy}, 32'd0);
    gap_ticks(1);
    chk("scan_start", {31'b0, busy}, 32'd1);
    run_idle(nt, nr, first, seen9);
    chk("scan_retunes", nr, 32'd1);
    chk("scan_wrap_nco", {12'b0, nco_phase_inc}, 32'h00100);
    chk("scan_gain", {29'b0, gain_out}, 32'd2);
    gap_ticks(3);
    cfg_phase_inc = 20'h05000;
    cfg_gain = 3'd2;
    cfg_valid = 1'b1;
    sample_tick = 1'b1;
    cyc();
    cfg_valid = 1'b0;
    sample_tick = 1'b0;
    scan_en = 1'b0;
    run_idle(nt, nr, first, seen9);
    chk("coinc_retunes", nr, 32'd1);
    chk("coinc_cfg_wins", {12'b0, nco_phase_inc}, 32'h05000);
    m_nco = 20'h05000;
    m_gain = 2;
    // Carry out of the phase adder also wraps to scan_min
    run_req(20'hC0000, 2, nt, nr);
    scan_max = 20'hFFFFF;
    scan_step = 20'h80000;
    scan_en = 1'b1;
    gap_ticks(4);
    scan_en = 1'b0;
    run_idle(nt, nr, first, seen9);
    chk("carry_wrap_nco", {12'b0, nco_phase_inc}, 32'h00100);
    m_nco = 20'h00100;
    // Async reset while settling drops the pending request
    send_cfg(20'h0D000, 3'd3);
    gap_ticks(3);
    chk("pre_rst_retuned_nco", {12'b0, nco_phase_inc}, 32'h0D000);
    send_cfg(20'h0E000, 3'd1);
    tick();
    #2 RSTb = 1'b0;
    #1;
    chk("arst_nco", {12'b0, nco_phase_inc}, 32'h07380);
    chk("arst_gain", {29'b0, gain_out}, 32'd5);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_retuned", {31'b0, retuned}, 32'd0);
    #1 RSTb = 1'b1;
    cyc();
    r0 = ret_total;
    gap_ticks(12);
    chk("arst_pending_dropped", ret_total - r0, 32'd0);
    chk("arst_idle", {31'b0, busy}, 32'd0);
    chk("arst_nco_hold", {12'b0, nco_phase_inc}, 32'h07380);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish, %0d of %0d checks failed so far", fails, tests);
    $fatal(1, "timeout");
  end
endmodule
